// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard for decode issue; stall/issue_accept are combinational, state updates on next edge.
// Backpressure: stalls decode on RAW, saturated WAW counter, flush, and for DRAIN_CYCLES after a flush.
module decode_scoreboard #(
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = 3,
    parameter int CNT_W        = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_uses_rs,
    input  logic                issue_uses_rd,
    input  logic [ADDR_W-1:0]   issue_rs,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_writes,
    input  logic [ADDR_W-1:0]   issue_dst,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic                flush,
    output logic                stall,
    output logic                issue_accept,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                underflow_err
);
    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {RUN, DRAIN} mode_t;

    mode_t              mode;
    logic [DW-1:0]      drain_cnt;
    logic [CNT_W-1:0]   cnt [NUM_REGS];
    logic               raw;
    logic               waw_full;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic               wb_underflow;

    always_comb begin
        raw      = (issue_uses_rs && cnt[issue_rs] != '0) ||
                   (issue_uses_rd && cnt[issue_rd] != '0);
        waw_full = issue_writes && cnt[issue_dst] == CNT_MAX;
        stall    = (mode == DRAIN) || flush || (issue_valid && (raw || waw_full));
        issue_accept = issue_valid && !stall;
        wb_underflow = wb_valid && cnt[wb_addr] == '0;
    end

    always_comb begin
        inc_vec   = '0;
        dec_vec   = '0;
        busy_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_vec[r]   = issue_accept && issue_writes && issue_dst == ADDR_W'(r);
            dec_vec[r]   = wb_valid && wb_addr == ADDR_W'(r) && cnt[r] != '0;
            busy_mask[r] = cnt[r] != '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode          <= RUN;
            drain_cnt     <= '0;
            underflow_err <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else if (flush) begin
            mode      <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else if (mode == RUN) begin
            if (wb_underflow) underflow_err <= 1'b1;
            // An increment and decrement on the same entry cancel out.
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec_vec[r] && !inc_vec[r])
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end else begin
            // Write-backs of squashed instructions are ignored while draining.
            drain_cnt <= drain_cnt - 1'b1;
            if (drain_cnt <= DW'(1)) begin
                mode      <= RUN;
                drain_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed vector bench for decode_scoreboard with hand-written async reset sequences.
module tb_decode_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_valid, issue_uses_rs, issue_uses_rd, issue_writes;
    logic [2:0] issue_rs, issue_rd, issue_dst, wb_addr;
    logic       wb_valid, flush;
    logic       stall, issue_accept, underflow_err;
    logic [7:0] busy_mask;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       iv, urs, urd;
        logic [2:0] rs, rd;
        logic       wr;
        logic [2:0] dst;
        logic       wbv;
        logic [2:0] wba;
        logic       fl;
        logic       e_stall, e_acc;
        logic [7:0] e_busy;
        logic       e_err;
    } vec_t;

    localparam int NV = 38;
    vec_t vecs [NV];

    decode_scoreboard #(.NUM_REGS(8), .ADDR_W(3), .CNT_W(2), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_uses_rs(issue_uses_rs), .issue_uses_rd(issue_uses_rd),
        .issue_rs(issue_rs), .issue_rd(issue_rd), .issue_writes(issue_writes), .issue_dst(issue_dst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
        .stall(stall), .issue_accept(issue_accept), .busy_mask(busy_mask), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_uses_rs = v.urs; issue_uses_rd = v.urd;
        issue_rs = v.rs; issue_rd = v.rd; issue_writes = v.wr; issue_dst = v.dst;
        wb_valid = v.wbv; wb_addr = v.wba; flush = v.fl;
    endtask

    task automatic idle();
        issue_valid = 0; issue_uses_rs = 0; issue_uses_rd = 0; issue_rs = 0; issue_rd = 0;
        issue_writes = 0; issue_dst = 0; wb_valid = 0; wb_addr = 0; flush = 0;
    endtask

    initial begin
        //            iv urs urd rs rd wr dst wbv wba fl | stall acc busy err
        vecs[0]  = '{0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,0}; // reset state
        vecs[1]  = '{1,0,0,0,0,1,2,0,0,0, 0,1,8'h00,0}; // write r2
        vecs[2]  = '{1,1,0,2,0,0,0,0,0,0, 1,0,8'h04,0}; // RAW on r2
        vecs[3]  = '{1,1,0,2,0,0,0,0,0,0, 1,0,8'h04,0};
        vecs[4]  = '{1,1,0,2,0,0,0,1,2,0, 1,0,8'h04,0}; // no bypass
        vecs[5]  = '{1,1,0,2,0,0,0,0,0,0, 0,1,8'h00,0};
        vecs[6]  = '{1,0,0,0,0,1,5,0,0,0, 0,1,8'h00,0}; // saturate r5
        vecs[7]  = '{1,0,0,0,0,1,5,0,0,0, 0,1,8'h20,0};
        vecs[8]  = '{1,0,0,0,0,1,5,0,0,0, 0,1,8'h20,0};
        vecs[9]  = '{1,0,0,0,0,1,5,0,0,0, 1,0,8'h20,0};
        vecs[10] = '{1,0,0,0,0,1,5,1,5,0, 1,0,8'h20,0};
        vecs[11] = '{1,0,0,0,0,1,5,0,0,0, 0,1,8'h20,0};
        vecs[12] = '{0,0,0,0,0,0,0,1,5,0, 0,0,8'h20,0};
        vecs[13] = '{0,0,0,0,0,0,0,1,5,0, 0,0,8'h20,0};
        vecs[14] = '{0,0,0,0,0,0,0,1,5,0, 0,0,8'h20,0};
        vecs[15] = '{1,0,0,0,0,1,1,0,0,0, 0,1,8'h00,0}; // write r1
        vecs[16] = '{1,0,1,0,1,0,0,0,0,0, 1,0,8'h02,0}; // RAW via Rd
        vecs[17] = '{1,0,0,0,0,1,1,1,1,0, 0,1,8'h02,0}; // inc+dec same reg
        vecs[18] = '{1,0,0,1,1,0,0,0,0,0, 0,1,8'h02,0}; // unused fields ignored
        vecs[19] = '{1,0,0,0,0,1,3,0,0,0, 0,1,8'h02,0};
        vecs[20] = '{1,0,0,0,0,1,3,0,0,0, 0,1,8'h0A,0};
        vecs[21] = '{1,0,0,0,0,1,6,0,0,0, 0,1,8'h0A,0};
        vecs[22] = '{1,0,0,0,0,1,0,0,0,1, 1,0,8'h4A,0}; // flush F
        vecs[23] = '{1,0,0,0,0,1,0,0,0,0, 1,0,8'h00,0};
        vecs[24] = '{1,0,0,0,0,1,0,1,3,0, 1,0,8'h00,0}; // wb in drain ignored
        vecs[25] = '{1,0,0,0,0,1,0,0,0,0, 1,0,8'h00,0};
        vecs[26] = '{1,0,0,0,0,1,0,0,0,0, 0,1,8'h00,0}; // F+4 accept
        vecs[27] = '{0,0,0,0,0,0,0,0,0,0, 0,0,8'h01,0};
        vecs[28] = '{0,0,0,0,0,0,0,0,0,1, 1,0,8'h01,0}; // flush, no issue
        vecs[29] = '{0,0,0,0,0,0,0,0,0,0, 1,0,8'h00,0};
        vecs[30] = '{0,0,0,0,0,0,0,0,0,1, 1,0,8'h00,0}; // re-flush in drain
        vecs[31] = '{1,0,0,0,0,0,0,0,0,0, 1,0,8'h00,0};
        vecs[32] = '{1,0,0,0,0,0,0,0,0,0, 1,0,8'h00,0};
        vecs[33] = '{1,0,0,0,0,0,0,0,0,0, 1,0,8'h00,0};
        vecs[34] = '{1,0,0,0,0,0,0,0,0,0, 0,1,8'h00,0};
        vecs[35] = '{0,0,0,0,0,0,0,1,7,0, 0,0,8'h00,0}; // underflow
        vecs[36] = '{0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,1};
        vecs[37] = '{1,0,0,0,0,0,0,1,7,0, 0,1,8'h00,1}; // sticky

        idle();
        #12 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d accept", i), 32'(issue_accept), 32'(vecs[i].e_acc));
            check($sformatf("v%0d busy", i), 32'(busy_mask), 32'(vecs[i].e_busy));
            check($sformatf("v%0d err", i), 32'(underflow_err), 32'(vecs[i].e_err));
            @(posedge clk); #1;
        end

        // Async reset mid-operation with a busy register and a set error.
        idle(); issue_valid = 1; issue_writes = 1; issue_dst = 4;
        @(posedge clk); #1;
        idle();
        #2;
        check("pre_rst busy", 32'(busy_mask), 32'h10);
        check("pre_rst err", 32'(underflow_err), 32'h1);
        rst = 1'b0; #1;
        check("rst_op busy", 32'(busy_mask), 32'h00);
        check("rst_op err", 32'(underflow_err), 32'h0);
        check("rst_op stall", 32'(stall), 32'h0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        // Async reset mid-drain.
        wb_valid = 1; wb_addr = 7;
        @(posedge clk); #1;
        idle(); flush = 1;
        @(posedge clk); #1;
        idle();
        #2;
        check("drain stall", 32'(stall), 32'h1);
        check("drain err", 32'(underflow_err), 32'h1);
        rst = 1'b0; #1;
        check("rst_drain stall", 32'(stall), 32'h0);
        check("rst_drain busy", 32'(busy_mask), 32'h00);
        check("rst_drain err", 32'(underflow_err), 32'h0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1; issue_writes = 1; issue_dst = 3;
        @(negedge clk);
        check("post_rst accept", 32'(issue_accept), 32'h1);
        check("post_rst stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check("post_rst busy", 32'(busy_mask), 32'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Register-hazard scoreboard that sequences instruction issue out of the decode stage. It tracks in-flight writes to each of the 8 register-file entries, from decode issue until the write-back port retires them. It stalls decode while a source register (Rs/Rd) still has an outstanding write, or while a destination's in-flight counter is saturated. After a pipeline flush it enforces a fixed drain window. It sits beside the decode stage's control unit / register file and drives the decode-stage stall.

## Interface
Parameters:
- NUM_REGS, 8, number of architectural registers
- ADDR_W, 3, register address width
- CNT_W, 2, width of per-register in-flight counter; max in-flight writes per register is 2^CNT_W-1 (3)
- DRAIN_CYCLES, 3, stall cycles after flush (decode-to-WB depth)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode holds a valid instruction
- issue_uses_rs  in  1  instruction reads Rs
- issue_uses_rd  in  1  instruction reads Rd
- issue_rs  in  ADDR_W  Rs field
- issue_rd  in  ADDR_W  Rd field
- issue_writes  in  1  instruction writes a register (from control signals)
- issue_dst  in  ADDR_W  destination register
- wb_valid  in  1  write-back write enable this cycle
- wb_addr  in  ADDR_W  write-back address
- flush  in  1  squash all younger in-flight instructions
- stall  out  1  hold decode (combinational)
- issue_accept  out  1  instruction leaves decode this cycle (combinational)
- busy_mask  out  NUM_REGS  bit r = counter r nonzero (registered state)
- underflow_err  out  1  sticky: wb to a register with zero count outside drain

## Operation
- State: cnt[r] (CNT_W bits) per register, mode ∈ {RUN, DRAIN}, drain_cnt, underflow_err.
- Hazard, when mode = RUN and issue_valid:
  - raw: (issue_uses_rs & cnt[issue_rs]≠0) | (issue_uses_rd & cnt[issue_rd]≠0).
  - waw_full: issue_writes & cnt[issue_dst] = max.
- stall = (mode=DRAIN) | flush | (issue_valid & (raw | waw_full)).
- issue_accept = issue_valid & ~stall.
- No write-back bypass: a source being written back in the same cycle still stalls. It is resolved the next cycle.
- Counter update in RUN, no flush, for each r:
  - inc = issue_accept & issue_writes & issue_dst=r.
  - dec = wb_valid & wb_addr=r & cnt[r]≠0.
  - cnt[r] += inc − dec; when inc and dec hit the same r, it is unchanged.
- wb_valid to a register with cnt=0 in RUN sets underflow_err. Otherwise it has no effect.
- Flush (any mode): all cnt ← 0, drain_cnt ← DRAIN_CYCLES, mode ← DRAIN. Flush overrides issue and wb in that cycle.
- DRAIN: stall=1. wb_valid is ignored (no decrement, no error). drain_cnt decrements each cycle; when drain_cnt=1, mode ← RUN next edge.
- Flush during DRAIN restarts drain_cnt at DRAIN_CYCLES.

## Timing
- Reset (async assert, rst=0): all cnt=0, mode=RUN, drain_cnt=0, underflow_err=0, busy_mask=0. stall=0 when issue_valid=0 and flush=0.
- stall and issue_accept are combinational from the current inputs and state. No added latency.
- Counter, mode and err updates take effect at the next rising edge. busy_mask reflects post-edge state.
- Issue of write to r at edge N sets busy_mask[r] after N. A dependent reader stalls until the edge after wb of r.
- Flush asserted during cycle F: stall=1 in F and in DRAIN_CYCLES following cycles. First possible accept is cycle F+DRAIN_CYCLES+1.
- Reset asserted mid-drain or mid-operation returns immediately to the reset state. Release is synchronous to the next edge.

## Test plan
- Basic RAW: issue write r2 (accepted) at cycle 0; at cycle 1 issue reader Rs=2 -> stall=1, busy_mask=0x04. Hold wb_valid,wb_addr=2 in cycle 3 -> stall still 1 in cycle 3, 0 in cycle 4, busy_mask=0x00.
- Saturation: three accepted writes to r5 without wb -> cnt[5]=3. A fourth writer to r5 -> stall=1. One wb to r5 -> the next cycle the fourth is accepted.
- Simultaneous inc/dec: cnt[1]=1, accept writer to r1 while wb_addr=1 -> cnt[1] stays 1, busy_mask[1]=1.
- Flush: cnt[3]=2, cnt[6]=1, flush at cycle 10 -> stall=1 in cycles 10–13, busy_mask=0x00 from cycle 11. wb to r3 at 12 gives no error. Accept at 14.
- Underflow: in RUN with all counts 0, wb_valid,wb_addr=7 -> underflow_err=1 and stays 1 until rst=0.
- Async reset mid-drain: rst=0 between edges during DRAIN -> stall=0, busy_mask=0, underflow_err=0 immediately.
